// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out serializer.
package piso_pkg;

    // Controller state: IDLE waits for a word, SHIFT streams one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Default frame width, matching the fixed 8-bit part this block replaces.
    localparam int PISO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_serializer.sv
// Parametrised PISO shift register with valid/ready load, selectable bit
// order, clock-inhibit freeze, serial cascade input and frame-done pulse.
// A word offered while the last bit of the current frame is on qh is loaded
// in place of the final shift, giving gapless back-to-back frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_inh,
    input  logic             ser_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             qh,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    bit_cnt
);

    // Index of the last bit of a frame, sized to the counter.
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    piso_state_e      state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic             done_reg, done_next;
    logic             last_bit;
    logic             accept;

    // The final bit of the frame is currently on qh.
    assign last_bit   = (bit_cnt_reg == LAST_IDX);

    // Ready in IDLE, or on the last bit so the next word follows without a gap.
    assign load_ready = !clk_inh &&
                        ((state_reg == IDLE) || ((state_reg == SHIFT) && last_bit));
    assign accept     = load_valid && load_ready;

    // Bit order is fixed at elaboration: build the shifted word and the
    // serial tap from LSB_FIRST so no runtime order mux exists.
    genvar gi;
    generate
        if (LSB_FIRST == 1'b0) begin : g_msb_first
            assign shifted[0] = ser_in;
            for (gi = 1; gi < WIDTH; gi++) begin : g_bit
                assign shifted[gi] = q_reg[gi-1];
            end
            assign qh = q_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign shifted[WIDTH-1] = ser_in;
            for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
                assign shifted[gi] = q_reg[gi+1];
            end
            assign qh = q_reg[0];
        end
    endgenerate

    // Next-state, datapath and done decode; everything holds while inhibited.
    always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        bit_cnt_next = bit_cnt_reg;
        done_next    = 1'b0;
        if (!clk_inh) begin
            // Done marks the final shift edge whether or not a new word loads.
            if ((state_reg == SHIFT) && last_bit) begin
                done_next = 1'b1;
            end
            if (accept) begin
                // A load takes precedence over the final shift.
                q_next       = load_data;
                bit_cnt_next = '0;
                state_next   = SHIFT;
            end else if (state_reg == SHIFT) begin
                q_next = shifted;
                if (last_bit) begin
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CW'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            bit_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            q_reg       <= q_next;
            bit_cnt_reg <= bit_cnt_next;
            done_reg    <= done_next;
        end
    end

    assign q       = q_reg;
    assign busy    = (state_reg == SHIFT);
    assign done    = done_reg;
    assign bit_cnt = bit_cnt_reg;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shift register with a valid/ready load handshake, selectable bit order, a clock-inhibit freeze and frame-complete signalling. It is the successor to our fixed 8-bit PISO and keeps its clk_inh and serial-cascade behaviour. It adds a frame bit counter, a done pulse, and gapless back-to-back frames. It sits between a parallel data source (FIFO or register file) and a serial link or daisy-chained shift stage.

Parameters:
WIDTH, 8, frame/register width in bits; legal range is WIDTH >= 2.
LSB_FIRST, 0, 0 = q[WIDTH-1] is shifted out first (74HC165 order); 1 = q[0] is shifted out first.
CW, $clog2(WIDTH), bit-counter width; localparam, not overridable.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
clk_inh  in  1  clock inhibit; 1 freezes all state except reset.
ser_in  in  1  serial cascade input, shifted into the vacated end.
load_valid  in  1  parallel word offered.
load_ready  out  1  block accepts a word this cycle.
load_data  in  WIDTH  parallel word.
qh  out  1  serial output; equals q[WIDTH-1] (LSB_FIRST=0) or q[0] (LSB_FIRST=1); combinational from q.
q  out  WIDTH  full register contents.
busy  out  1  high while in SHIFT.
done  out  1  one-cycle pulse after the final bit of a frame is shifted out.
bit_cnt  out  CW  index of the bit currently on qh; valid while busy.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets: state=IDLE, q=0, qh=0, bit_cnt=0, busy=0, done=0. Reset has priority over clk_inh and load. Reset mid-frame aborts the frame; done is not pulsed.
- Define an enabled edge as a rising clk edge with rst_n=1 and clk_inh=0.
- States: IDLE, SHIFT. The state type is a 1-bit enum.
- load_ready = !clk_inh && (state==IDLE || (state==SHIFT && bit_cnt==WIDTH-1)).
- Accept = load_valid && load_ready at an enabled edge. On accept: q<=load_data, bit_cnt<=0, state<=SHIFT.
- Latency: the first data bit is on qh in the cycle after the accept edge.
- SHIFT without accept, at an enabled edge:
  - LSB_FIRST=0: q<={q[WIDTH-2:0], ser_in}.
  - LSB_FIRST=1: q<={ser_in, q[WIDTH-1:1]}.
  - bit_cnt<=bit_cnt+1.
- Frame end: an enabled edge in SHIFT with bit_cnt==WIDTH-1 is the final shift.
  - done<=1 for exactly one cycle.
  - With no concurrent accept: perform the shift, state<=IDLE, bit_cnt<=0.
  - With a concurrent accept, load wins over the shift: the new word is loaded, state stays SHIFT, and done still pulses. Result: contiguous, gapless bit streams.
- Each data bit is held on qh for exactly one enabled cycle. A frame spans WIDTH enabled edges after the accept edge.
- clk_inh=1:
  - q, bit_cnt and state hold.
  - load_ready=0 and done=0 on edges where clk_inh=1.
  - A done that was already registered is still cleared after one cycle (it is never stretched).
- load_valid while load_ready=0 is ignored. The source must hold load_data and load_valid until accepted.
- In IDLE, q holds its last value (no free-running shift). qh reflects q.
- ser_in is sampled only at shift edges, so after a full frame q holds the last WIDTH serial-in samples.
- busy = (state==SHIFT), registered-state decode with no combinational input path.

Decomposition:
- Package piso_pkg holds the state enum typedef (IDLE, SHIFT).
- No sub-module is required. The counter, FSM and shift datapath fit in a single module.
- The bit-order mux is generated from LSB_FIRST via generate-if, not a runtime mux.

Test Plan:
- Reset then single frame (WIDTH=8, LSB_FIRST=0): load 8'b10110110 -> qh sequence 1,0,1,1,0,1,1,0 on the 8 cycles after accept; done pulses once on the 8th enabled edge; busy falls with it.
- LSB_FIRST=1 instance, load 8'b10110110 -> qh sequence 0,1,1,0,1,1,0,1; done timing identical to the previous case.
- clk_inh=1 for 3 cycles while bit_cnt=3 -> qh, q and bit_cnt frozen; load_ready=0; done delayed by exactly 3 cycles; bit order unchanged.
- Back-to-back: load_valid held with 8'hA5, then 8'h3C presented during the final bit -> 16 contiguous bits A5 then 3C with no idle cycle; done pulses twice, 8 cycles apart.
- Cascade: load 8'h00, ser_in=1 throughout -> q=8'hFF after done. Then load_valid during mid-frame (bit_cnt=4) -> not accepted; load_ready=0.
- Reset asserted at bit_cnt=5 -> next cycle q=0, qh=0, busy=0, done never pulses. Repeat the single-frame case on a WIDTH=16 instance with 16'hBEEF -> 16 correct bits.
